// File: rtl/gsr_sequencer_if.sv
// Reset-sequencer control/status bundle: software reset and holds in, channel resets and status out.
interface gsr_sequencer_if #(
    parameter int NUM_CH = 4
);
    logic              swrst;
    logic [NUM_CH-1:0] hold;
    logic [NUM_CH-1:0] gsrn;
    logic              ready;
    logic              busy;

    modport master (
        output swrst,
        output hold,
        input  gsrn,
        input  ready,
        input  busy
    );

    modport slave (
        input  swrst,
        input  hold,
        output gsrn,
        output ready,
        output busy
    );
endinterface

// File: rtl/gsr_sequencer.sv
// Global reset conditioner: asynchronous assert of all channels, synchronised and
// stretched release, then staggered per-channel release gated by per-channel holds.
module gsr_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 4,
    parameter int STAGGER     = 2,
    parameter int CNT_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    gsr_sequencer_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_CH + 1);

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CH);

    typedef enum logic [2:0] {
        ST_ASSERT  = 3'd0,
        ST_SYNC    = 3'd1,
        ST_STRETCH = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4
    } state_t;

    state_t                 state_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [IDX_W-1:0]       idx_r;
    logic [NUM_CH-1:0]      gsrn_r;
    logic                   ready_r;
    logic                   busy_r;

    logic [NUM_CH-1:0]      rel_mask_s;
    logic                   hold_cur_s;
    logic [CNT_W-1:0]       cnt_inc_s;

    // Select the channel currently in line for release and its hold bit; saturating counter step.
    always_comb begin
        rel_mask_s = NUM_CH'(1) << idx_r;
        hold_cur_s = |(bus.hold & rel_mask_s);
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_W'(1);
        end
    end

    // Sequencer FSM with registered channel resets and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_ASSERT;
            sync_r  <= {SYNC_STAGES{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            gsrn_r  <= {NUM_CH{1'b0}};
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
            // Software reset restarts the stretch from every state except ASSERT.
            if (bus.swrst && (state_r != ST_ASSERT)) begin
                state_r <= ST_STRETCH;
                cnt_r   <= {CNT_W{1'b0}};
                idx_r   <= {IDX_W{1'b0}};
                gsrn_r  <= {NUM_CH{1'b0}};
                ready_r <= 1'b0;
                busy_r  <= 1'b1;
            end else begin
                case (state_r)
                    ST_ASSERT: begin
                        state_r <= ST_SYNC;
                        busy_r  <= 1'b1;
                    end
                    ST_SYNC: begin
                        if (sync_r[SYNC_STAGES-1]) begin
                            state_r <= ST_STRETCH;
                            cnt_r   <= {CNT_W{1'b0}};
                        end
                    end
                    ST_STRETCH: begin
                        if (cnt_r >= STRETCH_LAST) begin
                            state_r <= ST_RELEASE;
                            if (!hold_cur_s) begin
                                gsrn_r <= gsrn_r | rel_mask_s;
                                idx_r  <= idx_r + IDX_W'(1);
                                cnt_r  <= {CNT_W{1'b0}};
                            end else begin
                                // Park the counter at "due" so RELEASE retries channel 0 every edge.
                                cnt_r <= STAGGER_LAST;
                            end
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                    ST_RELEASE: begin
                        if (idx_r == LAST_IDX) begin
                            state_r <= ST_RUN;
                            ready_r <= 1'b1;
                            busy_r  <= 1'b0;
                        end else if (cnt_r >= STAGGER_LAST) begin
                            if (!hold_cur_s) begin
                                gsrn_r <= gsrn_r | rel_mask_s;
                                idx_r  <= idx_r + IDX_W'(1);
                                cnt_r  <= {CNT_W{1'b0}};
                            end
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                    ST_RUN: begin
                        gsrn_r  <= {NUM_CH{1'b1}};
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_ASSERT;
                        cnt_r   <= {CNT_W{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        gsrn_r  <= {NUM_CH{1'b0}};
                        ready_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.gsrn  = gsrn_r;
    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;

endmodule

// File: tb/tb_gsr_sequencer.sv
// Scoreboard bench for gsr_sequencer: an edge-timing reference model queues expected outputs per edge.
module tb_gsr_sequencer;

    localparam int NUM_CH      = 3;
    localparam int SYNC_STAGES = 2;
    localparam int STRETCH     = 4;
    localparam int STAGGER     = 3;
    localparam int CNT_W       = 8;

    typedef struct packed {
        logic [NUM_CH-1:0] gsrn;
        logic              ready;
        logic              busy;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;

    int                m_edge;
    int                m_due;
    int                m_idx;
    int                m_ready_edge;
    logic [NUM_CH-1:0] m_gsrn;
    logic              m_ready;
    logic              m_busy;

    gsr_sequencer_if #(.NUM_CH(NUM_CH)) bus ();

    gsr_sequencer #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .STRETCH     (STRETCH),
        .STAGGER     (STAGGER),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, m_edge);
        end
    endtask

    task automatic model_reset();
        m_edge       = 0;
        m_due        = SYNC_STAGES + 1 + STRETCH;
        m_idx        = 0;
        m_ready_edge = -1;
        m_gsrn       = '0;
        m_ready      = 1'b0;
        m_busy       = 1'b0;
    endtask

    // Expected outputs after the next edge, from absolute release times.
    task automatic model_edge(input logic sw, input logic [NUM_CH-1:0] hv);
        m_edge++;
        if (m_edge == 1) begin
            m_busy = 1'b1;
        end else if (sw) begin
            m_gsrn       = '0;
            m_ready      = 1'b0;
            m_busy       = 1'b1;
            m_idx        = 0;
            m_due        = m_edge + STRETCH;
            m_ready_edge = -1;
        end else if (m_idx < NUM_CH) begin
            if (m_edge >= m_due && !hv[m_idx]) begin
                m_gsrn[m_idx] = 1'b1;
                m_idx++;
                m_due = m_edge + STAGGER;
                if (m_idx == NUM_CH) m_ready_edge = m_edge + 1;
            end
        end else if (m_edge == m_ready_edge) begin
            m_ready = 1'b1;
            m_busy  = 1'b0;
        end
    endtask

    // Called at a falling edge: drive, queue expectation, compare after the rising edge.
    task automatic step(input logic sw, input logic [NUM_CH-1:0] hv);
        exp_t e;
        bus.swrst = sw;
        bus.hold  = hv;
        model_edge(sw, hv);
        sb_q.push_back({m_gsrn, m_ready, m_busy});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val("gsrn",  {29'd0, bus.gsrn}, {29'd0, e.gsrn});
            check_val("ready", {31'd0, bus.ready}, {31'd0, e.ready});
            check_val("busy",  {31'd0, bus.busy},  {31'd0, e.busy});
        end
        @(negedge clk);
    endtask

    // Assert reset between edges, confirm outputs clear without a clock, release at a falling edge.
    task automatic apply_reset();
        @(posedge clk);
        #3;
        bus.swrst = 1'b0;
        bus.hold  = '0;
        rst = 1'b1;
        #1;
        check_val("rst_gsrn",  {29'd0, bus.gsrn}, 32'd0);
        check_val("rst_ready", {31'd0, bus.ready}, 32'd0);
        check_val("rst_busy",  {31'd0, bus.busy},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic scenario(input int n, input int sw_lo, input int sw_hi,
                            input logic [NUM_CH-1:0] hold_pat, input int hold_until,
                            input int tog_lo, input int tog_hi);
        logic              sw;
        logic [NUM_CH-1:0] hv;
        for (int e = 1; e <= n; e++) begin
            sw = (e >= sw_lo) && (e <= sw_hi);
            if (e <= hold_until) hv = hold_pat;
            else if (e >= tog_lo && e <= tog_hi) hv = (e % 2 == 0) ? 3'b111 : 3'b101;
            else hv = 3'b000;
            step(sw, hv);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        bus.swrst = 1'b0;
        bus.hold  = '0;
        model_reset();

        apply_reset();
        scenario(16, 0, -1, 3'b000, 0, 0, -1);
        apply_reset();
        scenario(16, 1, 1, 3'b000, 0, 0, -1);
        apply_reset();
        scenario(25, 0, -1, 3'b010, 14, 0, -1);
        apply_reset();
        scenario(45, 30, 30, 3'b000, 0, 20, 25);
        apply_reset();
        scenario(25, 10, 14, 3'b000, 0, 0, -1);
        apply_reset();
        scenario(9, 0, -1, 3'b000, 0, 0, -1);
        apply_reset();
        scenario(16, 0, -1, 3'b000, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
